dmem_arbiter: RTL

//  Shares the single-port 64x16 data memory between two requesters: port 0 = CPU

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 25 ++
 rtl/dmem.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory arbiter.
//   ADDR_W / DATA_W / DEPTH : default address width, data width and
//                             implemented word count (addr >= DEPTH is
//                             out of range).
//   PORT_CPU / PORT_DBG     : requester indices (load/store unit, debug).
//   state_t                 : arbiter FSM encoding.
package dmem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- bundle of every non-clock signal around the arbiter.
//   Requester side (x = 0 CPU, 1 debug):
//     reqx, wex, addrx, wdatax   requester -> arbiter
//     gntx, donex, errx, rdatax  arbiter -> requester
//   Memory side:
//     mem_we, mem_re, mem_addr, mem_wdata   arbiter -> memory
//     mem_rdata                             memory -> arbiter (comb read)
//   Modports: master = requesters + memory (environment), slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
);
    logic              req0,   req1;
    logic              we0,    we1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;

    logic              gnt0,   gnt1;
    logic              done0,  done1;
    logic              err0,   err1;
    logic [DATA_W-1:0] rdata0, rdata1;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2 -- two-input round-robin picker, purely combinational.
//   req  in  2  request vector, bit i = port i
//   last in  1  port that won the most recent contended arbitration
//   gnt  out 2  one-hot winner, all-zero when nobody requests
// The pointer register lives in the parent so it can decide when to move it.
module rr_arb2
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    import dmem_pkg::*;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt[PORT_CPU] = 1'b1;
            2'b10:   gnt[PORT_DBG] = 1'b1;
            // Contention: hand it to whoever did not win last time.
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem.sv
// dmem_arbiter -- shares a single-port data memory between the CPU
// load/store unit (port 0) and the debug/program-loader port (port 1).
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   bus    slave modport of dmem_arbiter_if (requesters + memory)
// One access in flight: IDLE -> ACCESS -> RESP -> IDLE, so at most one
// access every three cycles. gnt pulses in ACCESS, done/err/rdata in RESP.
// ADDR_W / DATA_W must match the connected interface instance.
module dmem_arbiter #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int DEPTH  = dmem_pkg::DEPTH
)(
    input  logic         clk,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);
    import dmem_pkg::*;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic              lastGnt;     // winner of last contended arbitration
    logic [1:0]        reqVec;
    logic [1:0]        pick;

    // Winner's request, muxed before it is latched.
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selOk;

    // Access in flight.
    logic              curPort;
    logic              curWe;
    logic              curOk;

    // Registered outputs.
    logic [1:0]        gntQ;
    logic [1:0]        doneQ;
    logic [1:0]        errQ;
    logic [DATA_W-1:0] rdata0Q;
    logic [DATA_W-1:0] rdata1Q;
    logic              memWeQ;
    logic              memReQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWdataQ;
    logic [DATA_W-1:0] capData;

    assign reqVec = {bus.req1, bus.req0};

    rr_arb2 uArb (
        .req  (reqVec),
        .last (lastGnt),
        .gnt  (pick)
    );

    always_comb begin
        selWe    = bus.we0;
        selAddr  = bus.addr0;
        selWdata = bus.wdata0;
        if (pick[PORT_DBG]) begin
            selWe    = bus.we1;
            selAddr  = bus.addr1;
            selWdata = bus.wdata1;
        end
        // Full-width compare: an address at or past DEPTH never aliases.
        selOk = {1'b0, selAddr} < LIMIT;
    end

    // Read data seen at the end of ACCESS; writes and errors return 0.
    assign capData = (curOk && !curWe) ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lastGnt   <= 1'b1;          // port 0 wins the first tie
            curPort   <= 1'b0;
            curWe     <= 1'b0;
            curOk     <= 1'b0;
            gntQ      <= '0;
            doneQ     <= '0;
            errQ      <= '0;
            rdata0Q   <= '0;
            rdata1Q   <= '0;
            memWeQ    <= 1'b0;
            memReQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        state     <= ACCESS;
                        curPort   <= pick[PORT_DBG];
                        curWe     <= selWe;
                        curOk     <= selOk;
                        gntQ      <= pick;
                        // Out-of-range accesses never touch the memory.
                        memWeQ    <= selOk &  selWe;
                        memReQ    <= selOk & ~selWe;
                        memAddrQ  <= selOk ? selAddr  : '0;
                        memWdataQ <= selOk ? selWdata : '0;
                        // The pointer only moves on contention, so a lone
                        // requester does not steal the loser's next turn.
                        if (&reqVec) lastGnt <= pick[PORT_DBG];
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    gntQ      <= '0;
                    memWeQ    <= 1'b0;
                    memReQ    <= 1'b0;
                    memAddrQ  <= '0;
                    memWdataQ <= '0;
                    doneQ     <= curPort ? 2'b10 : 2'b01;
                    errQ      <= curOk ? 2'b00 : (curPort ? 2'b10 : 2'b01);
                    if (curPort) rdata1Q <= capData;
                    else         rdata0Q <= capData;
                end
                RESP: begin
                    state <= IDLE;
                    doneQ <= '0;
                    errQ  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0   = gntQ[PORT_CPU];
    assign bus.gnt1   = gntQ[PORT_DBG];
    assign bus.done0  = doneQ[PORT_CPU];
    assign bus.done1  = doneQ[PORT_DBG];
    assign bus.err0   = errQ[PORT_CPU];
    assign bus.err1   = errQ[PORT_DBG];
    assign bus.rdata0 = rdata0Q;
    assign bus.rdata1 = rdata1Q;

    // Reset arriving during ACCESS must stop the write that would commit at
    // the same edge, so the strobes are killed combinationally by reset.
    assign bus.mem_we    = memWeQ & ~reset;
    assign bus.mem_re    = memReQ & ~reset;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;

endmodule
